// File: rtl/riscv_mux_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mux_pkg
// Constants shared by the datapath select stages.
//   DEFAULT_WIDTH : datapath word width
//   MAX_MUX_IN    : largest supported input count for result_mux_pipe
//   wb_sel_e      : select encodings of the 3-way writeback select
// ---------------------------------------------------------------------------
package riscv_mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_MUX_IN    = 16;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_MEM = 2'd1,
        SEL_PC4 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/result_skid_buf.sv
// ---------------------------------------------------------------------------
// result_skid_buf
// Two-entry valid/ready skid buffer: output register O plus skid register S.
// in_ready comes straight from the S valid flop, so out_ready never reaches
// in_ready combinationally.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_payload/valid/ready : upstream handshake
//   out_payload/valid/ready: downstream handshake (out_payload is O contents)
// ---------------------------------------------------------------------------
module result_skid_buf #(
    parameter int PAYLOAD_W = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic                 o_valid_q, o_valid_d;
    logic [PAYLOAD_W-1:0] o_data_q,  o_data_d;
    logic                 s_valid_q, s_valid_d;
    logic [PAYLOAD_W-1:0] s_data_q,  s_data_d;

    logic accept;
    logic o_free;

    assign in_ready    = !s_valid_q;
    assign out_valid   = o_valid_q;
    assign out_payload = o_data_q;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        accept = in_valid && !s_valid_q;
        // O can take a new word when empty or being emitted this cycle.
        o_free = !o_valid_q || out_ready;

        if (o_free) begin
            if (s_valid_q) begin
                // S always holds the older beat, so it drains first.
                o_valid_d = 1'b1;
                o_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                o_valid_d = 1'b1;
                o_data_d  = in_payload;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/result_mux_pipe.sv
// ---------------------------------------------------------------------------
// result_mux_pipe
// Registered NUM_IN:1 result select. The selected word (zero for an
// out-of-range select) is pushed through a two-entry skid buffer.
// Optional feature macro: SEL_ERR_EN -- carries an illegal-select flag with
// each beat (out_sel_err), keeps a sticky flag (err_sticky) and adds a
// simulation assertion on illegal accepts. Undefined: both outputs tied 0.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_data              : NUM_IN flattened words, input i at [i*WIDTH +: WIDTH]
//   in_sel               : select for the current beat
//   in_valid / in_ready  : upstream handshake (in_ready is a flop output)
//   out_data / out_valid / out_ready : downstream handshake
//   out_sel_err          : current output beat came from an illegal select
//   err_sticky           : an illegal select was accepted since reset
// NUM_IN must lie in 2..MAX_MUX_IN; SEL_W is derived and not overridden.
// ---------------------------------------------------------------------------
module result_mux_pipe
    import riscv_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sel_err,
    output logic                    err_sticky
);

    logic [WIDTH-1:0] sel_word;
`ifdef SEL_ERR_EN
    logic sel_legal;
`endif

    // Only in-range selects match; anything else leaves the word at zero.
    always_comb begin
        sel_word = '0;
`ifdef SEL_ERR_EN
        sel_legal = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_word = in_data[i*WIDTH +: WIDTH];
`ifdef SEL_ERR_EN
                sel_legal = 1'b1;
`endif
            end
        end
    end

`ifdef SEL_ERR_EN
    localparam int PAYLOAD_W = WIDTH + 1;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 accept;
    logic                 err_sticky_q, err_sticky_d;

    assign in_payload  = {!sel_legal, sel_word};
    assign out_data    = out_payload[WIDTH-1:0];
    assign out_sel_err = out_payload[WIDTH];
    assign accept      = in_valid && in_ready;
    assign err_sticky  = err_sticky_q;

    always_comb begin
        err_sticky_d = err_sticky_q;
        if (accept && !sel_legal) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

`ifndef SYNTHESIS
    a_legal_sel: assert property (@(posedge clk) disable iff (rst) accept |-> sel_legal);
`endif

`else
    localparam int PAYLOAD_W = WIDTH;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign in_payload  = sel_word;
    assign out_data    = out_payload;
    assign out_sel_err = 1'b0;
    assign err_sticky  = 1'b0;
`endif

    result_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_payload  (in_payload),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_payload (out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

endmodule

// File: tb/tb_result_mux_pipe.sv
module tb_result_mux_pipe;

`ifdef SEL_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    // 3-input, 32-bit instance
    logic [95:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sel_err;
    logic        err_sticky;

    // 8-input, 16-bit instance
    logic [127:0] in_data8;
    logic [2:0]   in_sel8;
    logic         in_valid8;
    logic         in_ready8;
    logic [15:0]  out_data8;
    logic         out_valid8;
    logic         out_ready8;
    logic         out_sel_err8;
    logic         err_sticky8;

    int errors;
    int checks;

    result_mux_pipe #(
        .WIDTH  (32),
        .NUM_IN (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel_err (out_sel_err),
        .err_sticky  (err_sticky)
    );

    result_mux_pipe #(
        .WIDTH  (16),
        .NUM_IN (8)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data8),
        .in_sel      (in_sel8),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .out_data    (out_data8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .out_sel_err (out_sel_err8),
        .err_sticky  (err_sticky8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", out_sel_err); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_dut8: valid %b ready %b want 0 1", out_valid8, in_ready8); end
    endtask

    task automatic test_single();
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h22222222) begin errors++; $display("FAIL single_data: got %h want 22222222", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sels [4];
        logic [31:0] exps [4];
        sels = '{2'd0, 2'd1, 2'd2, 2'd0};
        exps = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel   = sels[i];
            in_valid = 1'b1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== exps[i]) begin errors++; $display("FAIL b2b_beat%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, exps[i]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h33333333) begin errors++; $display("FAIL bp_first: got v=%b %h want v=1 33333333", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b want 1", in_ready); end
        in_sel = 2'd0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b want 0", in_ready); end
        checks++; if (out_data !== 32'h33333333) begin errors++; $display("FAIL bp_stable1: got %h want 33333333", out_data); end
        // offered but must not be taken while full
        in_sel = 2'd1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h33333333) begin errors++; $display("FAIL bp_stable2: got v=%b %h want v=1 33333333", out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11111111) begin errors++; $display("FAIL bp_release1: got v=%b %h want v=1 11111111", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h22222222) begin errors++; $display("FAIL bp_release2: got v=%b %h want v=1 22222222", out_valid, out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal_sel();
        out_ready = 1'b1;
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin errors++; $display("FAIL illegal_data: got v=%b %h want v=1 0", out_valid, out_data); end
        checks++; if (out_sel_err !== ERR_ON) begin errors++; $display("FAIL illegal_err: got %b want %b", out_sel_err, ERR_ON); end
        checks++; if (err_sticky !== ERR_ON) begin errors++; $display("FAIL illegal_sticky: got %b want %b", err_sticky, ERR_ON); end
        in_sel = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_data !== 32'h33333333 || out_sel_err !== 1'b0) begin errors++; $display("FAIL illegal_next: got %h err=%b want 33333333 err=0", out_data, out_sel_err); end
        @(negedge clk);
        checks++; if (err_sticky !== ERR_ON) begin errors++; $display("FAIL sticky_hold: got %b want %b", err_sticky, ERR_ON); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        @(negedge clk);
        in_sel = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: ready %b valid %b want 0 1", in_ready, out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL mid_sticky: got %b want 0", err_sticky); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_ghost: got %b want 0", out_valid); end
    endtask

    task automatic test_random8();
        logic [15:0]  q[$];
        logic [127:0] d;
        logic [15:0]  w;
        for (int c = 0; c < 3000; c++) begin
            in_data8   = {$urandom, $urandom, $urandom, $urandom};
            in_sel8    = 3'($urandom_range(7));
            in_valid8  = ($urandom_range(3) != 0);
            out_ready8 = ($urandom_range(2) != 0);
            checks++; if (out_valid8 !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid8, q.size() != 0); end
            checks++; if (in_ready8 !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready8, q.size() < 2); end
            if (out_valid8 && out_ready8 && q.size() != 0) begin
                w = q.pop_front();
                checks++; if (out_data8 !== w) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data8, w); end
            end
            if (in_valid8 && in_ready8) begin
                d = in_data8;
                q.push_back(d[in_sel8*16 +: 16]);
            end
            @(negedge clk);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid8 && q.size() != 0) begin
                w = q.pop_front();
                checks++; if (out_data8 !== w) begin errors++; $display("FAIL rnd_drain_data: got %h want %h", out_data8, w); end
            end
            @(negedge clk);
        end
        checks++; if (q.size() != 0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL rnd_drain: left %0d valid %b want 0 0", q.size(), out_valid8); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        in_data    = {32'h33333333, 32'h22222222, 32'h11111111};
        in_sel     = 2'd0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data8   = '0;
        in_sel8    = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal_sel();
        test_reset_mid();
        test_random8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
